// File: rtl/tokenflow_pkg.sv
// Shared constants and types for the tokenflow x*(x+1) token source.
// Optional feature macro: TOKENFLOW_ACK_SYNC_EN (see tokenflow_chan_out).
package tokenflow_pkg;

  localparam int TOKEN_W_DEFAULT = 26;
  localparam int FOLD_W          = 15;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } phase_e;

endpackage

// File: rtl/tokenflow_chan_out.sv
// Four-phase request/acknowledge output stage: phase FSM, data register and
// an optional two-flop ack synchronizer enabled by TOKENFLOW_ACK_SYNC_EN.
module tokenflow_chan_out
  import tokenflow_pkg::*;
#(
  parameter int W = TOKEN_W_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] next_data,
  output logic         consumed,
  output logic         ou_req,
  output logic [W-1:0] ou_data,
  input  logic         ou_ack
);

  localparam logic [0:0] ST_EMPTY = EMPTY;
  localparam logic [0:0] ST_FULL  = FULL;

  logic [0:0] state;
  logic       ack_seen;

`ifdef TOKENFLOW_ACK_SYNC_EN
  // The consumer may live in another clock domain; two flops settle the ack.
  logic [1:0] ack_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      ack_sync <= 2'b00;
    end else begin
      ack_sync <= {ack_sync[0], ou_ack};
    end
  end

  assign ack_seen = ack_sync[1];
`else
  assign ack_seen = ou_ack;
`endif

  // Data is captured only on entry to FULL, so it is stable while req is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_EMPTY;
      ou_data <= '0;
    end else if (state == ST_EMPTY) begin
      if (!ack_seen) begin
        state   <= ST_FULL;
        ou_data <= next_data;
      end
    end else begin
      if (ack_seen) begin
        state <= ST_EMPTY;
      end
    end
  end

  assign ou_req   = (state == ST_FULL);
  assign consumed = (state == ST_FULL) && ack_seen;

endmodule

// File: rtl/tokenflow.sv
// Token generator x*(x+1) mod 2^W feeding a four-phase output channel.
// Optional feature macro: TOKENFLOW_ACK_SYNC_EN (ack synchronizer in channel).
module tokenflow
  import tokenflow_pkg::*;
#(
  parameter int W = TOKEN_W_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  output logic         ou_req,
  output logic [W-1:0] ou_data,
  input  logic         ou_ack
);

  logic [W-1:0] x;
  logic [W-1:0] token;
  logic         consumed;

  // Running sum: (x+1)(x+2) - x(x+1) = 2(x+1); exact modulo 2^W, including wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      x     <= '0;
      token <= '0;
    end else if (consumed) begin
      x     <= x + W'(1);
      token <= token + ((x + W'(1)) << 1);
    end
  end

  tokenflow_chan_out #(
    .W(W)
  ) u_chan_out (
    .clk      (clk),
    .reset    (reset),
    .next_data(token),
    .consumed (consumed),
    .ou_req   (ou_req),
    .ou_data  (ou_data),
    .ou_ack   (ou_ack)
  );

endmodule

// File: tb/tb_tokenflow.sv
// Self-checking bench for tokenflow: a W=26 and a W=4 instance checked every
// cycle against a token-count model, plus literal sequence/timing expectations.
module tb_tokenflow;

  localparam int WA = 26;
  localparam int WB = 4;
`ifdef TOKENFLOW_ACK_SYNC_EN
  localparam int      LAT     = 3;
  localparam bit      SYNC    = 1'b1;
  localparam longint  S3_DATA = 2;
`else
  localparam int      LAT     = 1;
  localparam bit      SYNC    = 1'b0;
  localparam longint  S3_DATA = 0;
`endif
  localparam int PER = 2 * LAT;

  logic          clk;
  logic          rst_a, ack_a, req_a;
  logic [WA-1:0] data_a;
  logic          rst_b, ack_b, req_b;
  logic [WB-1:0] data_b;

  int checks = 0;
  int errors = 0;

  longint rise_a[$];
  int     risecyc_a[$];
  longint rise_b[$];

  tokenflow #(.W(WA)) dut_a (
    .clk(clk), .reset(rst_a), .ou_req(req_a), .ou_data(data_a), .ou_ack(ack_a)
  );

  tokenflow #(.W(WB)) dut_b (
    .clk(clk), .reset(rst_b), .ou_req(req_b), .ou_data(data_b), .ou_ack(ack_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic longint tok(input longint k, input int w);
    longint m;
    m = (longint'(1) << w) - 1;
    return (k * (k + 1)) & m;
  endfunction

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit loop_a, input bit loop_b);
    @(posedge clk);
    #1;
    if (loop_a) ack_a = req_a;
    if (loop_b) ack_b = req_b;
  endtask

  // Model: req follows the inverse of the ack the FSM sees; token index counts
  // completed handshakes and the presented value is k*(k+1) mod 2^W.
  bit     ma_req, ma_h1, ma_h2, ma_armed;
  longint ma_data, ma_k;
  int     cnt_a;
  bit     mb_req, mb_h1, mb_h2, mb_armed;
  longint mb_data, mb_k;

  always @(posedge clk) begin
    bit seen;
    if (rst_a) begin
      ma_req = 0; ma_data = 0; ma_k = 0; ma_h1 = 0; ma_h2 = 0; ma_armed = 1; cnt_a = 0;
    end else begin
      seen  = SYNC ? ma_h2 : ack_a;
      ma_h2 = ma_h1;
      ma_h1 = ack_a;
      if (!seen && !ma_req) ma_data = tok(ma_k, WA);
      if (seen && ma_req) ma_k = (ma_k + 1) & ((longint'(1) << WA) - 1);
      ma_req = !seen;
      cnt_a++;
    end
  end

  always @(posedge clk) begin
    bit seen;
    if (rst_b) begin
      mb_req = 0; mb_data = 0; mb_k = 0; mb_h1 = 0; mb_h2 = 0; mb_armed = 1;
    end else begin
      seen  = SYNC ? mb_h2 : ack_b;
      mb_h2 = mb_h1;
      mb_h1 = ack_b;
      if (!seen && !mb_req) mb_data = tok(mb_k, WB);
      if (seen && mb_req) mb_k = (mb_k + 1) & ((longint'(1) << WB) - 1);
      mb_req = !seen;
    end
  end

  bit prev_req_a = 0;
  bit prev_req_b = 0;

  always @(negedge clk) begin
    if (ma_armed) begin
      checkOutput("a_req", longint'(req_a), longint'(ma_req));
      checkOutput("a_data", longint'(data_a), ma_data);
    end
    if (mb_armed) begin
      checkOutput("b_req", longint'(req_b), longint'(mb_req));
      checkOutput("b_data", longint'(data_b), mb_data);
    end
    if (!rst_a && req_a && !prev_req_a) begin
      rise_a.push_back(longint'(data_a));
      risecyc_a.push_back(cnt_a - 1);
    end
    if (!rst_b && req_b && !prev_req_b) rise_b.push_back(longint'(data_b));
    prev_req_a = req_a;
    prev_req_b = req_b;
  end

  initial begin
    longint exp1[7]  = '{0, 2, 6, 12, 20, 30, 42};
    longint exp4[17] = '{0, 2, 6, 12, 4, 14, 10, 8, 8, 10, 14, 4, 12, 6, 2, 0, 0};
    bit found;

    rst_a = 1; ack_a = 0; rst_b = 1; ack_b = 0;

    // Loopback sequence and timing on the wide instance.
    repeat (2) applyStimulus(0, 0);
    rst_a = 0;
    rise_a.delete(); risecyc_a.delete();
    for (int i = 0; i < 100 && rise_a.size() < 7; i++) applyStimulus(1, 0);
    if (rise_a.size() < 7) begin
      checkOutput("s1_timeout", longint'(rise_a.size()), 7);
    end else begin
      for (int i = 0; i < 7; i++) begin
        checkOutput("s1_data", rise_a[i], exp1[i]);
        checkOutput("s1_cycle", longint'(risecyc_a[i]), longint'(i * PER));
      end
    end

    // Consumer stalls with ack low: req and data must hold.
    rst_a = 1; ack_a = 0;
    repeat (2) applyStimulus(0, 0);
    rst_a = 0;
    for (int i = 0; i < 10 && !req_a; i++) applyStimulus(0, 0);
    checkOutput("s2_first_req", longint'(req_a), 1);
    repeat (50) applyStimulus(0, 0);
    checkOutput("s2_hold_req", longint'(req_a), 1);
    checkOutput("s2_hold_data", longint'(data_a), 0);
    ack_a = 1;
    for (int i = 0; i < 10 && req_a; i++) applyStimulus(0, 0);
    checkOutput("s2_req_fall", longint'(req_a), 0);
    ack_a = 0;
    for (int i = 0; i < 10 && !req_a; i++) applyStimulus(0, 0);
    checkOutput("s2_next_req", longint'(req_a), 1);
    checkOutput("s2_next_data", longint'(data_a), 2);

    // Ack held high across reset release.
    rst_a = 1; ack_a = 1;
    repeat (2) applyStimulus(0, 0);
    rst_a = 0;
    repeat (20) applyStimulus(0, 0);
    checkOutput("s3_idle_req", longint'(req_a), 0);
    ack_a = 0;
    repeat (LAT) applyStimulus(0, 0);
    checkOutput("s3_req", longint'(req_a), 1);
    checkOutput("s3_data", longint'(data_a), S3_DATA);

    // Reset while presenting token 12.
    rst_a = 1; ack_a = 0;
    repeat (2) applyStimulus(0, 0);
    rst_a = 0;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge clk);
      #1;
      if (req_a && data_a == WA'(12)) found = 1;
      else ack_a = req_a;
    end
    checkOutput("s5_reach_12", longint'(found), 1);
    rst_a = 1;
    applyStimulus(0, 0);
    checkOutput("s5_rst_req", longint'(req_a), 0);
    checkOutput("s5_rst_data", longint'(data_a), 0);
    rst_a = 0; ack_a = 0;
    rise_a.delete(); risecyc_a.delete();
    for (int i = 0; i < 20 && rise_a.size() < 1; i++) applyStimulus(1, 0);
    if (rise_a.size() < 1) checkOutput("s5_timeout", 0, 1);
    else checkOutput("s5_first_token", rise_a[0], 0);

    // Narrow instance: wrap of x*(x+1) mod 16.
    rst_b = 0;
    rise_b.delete();
    for (int i = 0; i < 17 * PER + 20 && rise_b.size() < 17; i++) applyStimulus(0, 1);
    if (rise_b.size() < 17) begin
      checkOutput("s4_timeout", longint'(rise_b.size()), 17);
    end else begin
      for (int i = 0; i < 17; i++) checkOutput("s4_data", rise_b[i], exp4[i]);
    end

    repeat (2) applyStimulus(0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
